// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared widths and state encodings for the Montgomery datapath
package multiplier_pkg;

    localparam int DATA_LENGTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_X = 2'd1,
        SHIFT_R = 2'd2,
        DONE    = 2'd3
    } tm_state_t;

endpackage

// File: rtl/mod_double_step.sv
// rtl/mod_double_step.sv - one modular doubling step: r_next = (2r + b) mod m, given r < m
module mod_double_step #(
    parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
    input  logic [DATA_LENGTH:0]   r,
    input  logic                   b,
    input  logic [DATA_LENGTH-1:0] m,
    output logic [DATA_LENGTH:0]   r_next
);

    logic [DATA_LENGTH:0] t;
    logic [DATA_LENGTH:0] m_ext;
    logic                 ge;

    assign t     = {r[DATA_LENGTH-1:0], b};
    assign m_ext = {1'b0, m};
    // A set top bit of r would push 2r past 2^(DATA_LENGTH+1) > m, so it forces the subtract.
    assign ge    = r[DATA_LENGTH] || (t >= m_ext);

    always_comb begin
        r_next = t;
        if (ge) begin
            r_next = t - m_ext;
        end
    end

endmodule

// File: rtl/to_montgomery_bs.sv
// rtl/to_montgomery_bs.sv - bit-serial conversion into Montgomery form: (x * 2^k) mod m
module to_montgomery_bs #(
    parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] x_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [DATA_LENGTH-1:0] result_o
);

    import multiplier_pkg::*;

    localparam int CW = $clog2(DATA_LENGTH) + 1;
    localparam logic [DATA_LENGTH-1:0] DL_VEC = DATA_LENGTH'(DATA_LENGTH);

    tm_state_t state_q;
    tm_state_t state_d;

    logic [CW-1:0]          cnt_q;
    logic [DATA_LENGTH-1:0] x_sh_q;
    logic [DATA_LENGTH-1:0] m_q;
    logic [DATA_LENGTH-1:0] k_q;
    logic [DATA_LENGTH:0]   r_q;
    logic [DATA_LENGTH:0]   r_step;
    logic                   err_q;

    logic illegal;
    logic last_x;
    logic last_r;
    logic accept;
    logic step_en;
    logic step_bit;
    logic cnt_wrap;

    assign illegal = !m_i[0] || (m_bl_i > DL_VEC);
    assign last_x  = (cnt_q == CW'(DATA_LENGTH - 1));
    assign last_r  = ((DATA_LENGTH'(cnt_q) + DATA_LENGTH'(1)) == k_q);

    mod_double_step #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_step (
        .r      (r_q),
        .b      (step_bit),
        .m      (m_q),
        .r_next (r_step)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = illegal ? DONE : SHIFT_X;
                end
            end
            SHIFT_X: begin
                if (last_x) begin
                    state_d = (k_q == '0) ? DONE : SHIFT_R;
                end
            end
            SHIFT_R: begin
                if (last_r) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        accept   = (state_q == IDLE) && start_i;
        step_en  = (state_q == SHIFT_X) || (state_q == SHIFT_R);
        step_bit = (state_q == SHIFT_X) && x_sh_q[DATA_LENGTH-1];
        cnt_wrap = ((state_q == SHIFT_X) && last_x) || ((state_q == SHIFT_R) && last_r);
    end

    // x is consumed MSB first by shifting the latched copy left each step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_sh_q <= '0;
            m_q    <= '0;
            k_q    <= '0;
            err_q  <= 1'b0;
            r_q    <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            x_sh_q <= x_i;
            m_q    <= m_i;
            k_q    <= m_bl_i;
            err_q  <= illegal;
            r_q    <= '0;
            cnt_q  <= '0;
        end else if (step_en) begin
            x_sh_q <= {x_sh_q[DATA_LENGTH-2:0], 1'b0};
            r_q    <= r_step;
            cnt_q  <= cnt_wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= (state_q == DONE);
            err_o   <= (state_q == DONE) && err_q;
            if (state_q == DONE) begin
                result_o <= err_q ? '0 : r_q[DATA_LENGTH-1:0];
            end
        end
    end

endmodule
